// File: rtl/frame_diff_filter_if.sv
// frame_diff_filter_if
//   Bundles the pixel-stream handshake, result stream, motion counter and
//   VIP control passthrough signals of frame_diff_filter_core.
//   master : the environment (sources A/B beats, sinks results)
//   slave  : the core
interface frame_diff_filter_if #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int COUNT_BITS       = 32
);
    localparam int W = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

    // input pixel stream
    logic                       stall_in;
    logic                       read;
    logic [W-1:0]               data_A_in;
    logic [W-1:0]               data_B_in;
    logic                       end_of_video;
    logic [1:0]                 mode_in;
    logic [BITS_PER_SYMBOL-1:0] threshold_in;
    // result stream
    logic                       stall_out;
    logic                       write;
    logic [W-1:0]               data_out;
    logic                       end_of_video_out;
    // per-frame motion statistic
    logic [COUNT_BITS-1:0]      motion_count_out;
    logic                       motion_count_valid;
    // VIP control packet fields
    logic [15:0]                width_in;
    logic [15:0]                height_in;
    logic [3:0]                 interlaced_in;
    logic                       vip_ctrl_valid_in;
    logic [15:0]                width_out;
    logic [15:0]                height_out;
    logic [3:0]                 interlaced_out;
    logic                       vip_ctrl_valid_out;

    modport master (
        output stall_in, data_A_in, data_B_in, end_of_video, mode_in, threshold_in,
        output stall_out,
        output width_in, height_in, interlaced_in, vip_ctrl_valid_in,
        input  read, write, data_out, end_of_video_out,
        input  motion_count_out, motion_count_valid,
        input  width_out, height_out, interlaced_out, vip_ctrl_valid_out
    );

    modport slave (
        input  stall_in, data_A_in, data_B_in, end_of_video, mode_in, threshold_in,
        input  stall_out,
        input  width_in, height_in, interlaced_in, vip_ctrl_valid_in,
        output read, write, data_out, end_of_video_out,
        output motion_count_out, motion_count_valid,
        output width_out, height_out, interlaced_out, vip_ctrl_valid_out
    );
endinterface

// File: rtl/frame_diff_filter_core.sv
// frame_diff_filter_core
//   Per-pixel difference filter over two aligned pixel streams A and B.
//   Each accepted beat goes through a registered difference stage (S1), a
//   combinational mode-select stage (S2) and a credit-controlled output FIFO.
//   mode 00 absdiff, 01 saturating A-B, 10 per-channel threshold mask,
//   11 whole-pixel motion mask. Mode/threshold are latched at frame start.
//   A per-frame count of pixels whose largest channel difference exceeds the
//   threshold is published at end of frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : frame_diff_filter_if.slave (streams, counter, VIP passthrough)

// Single-channel difference: absolute value and A-B clamped at zero.
module frame_diff_lane #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] d,
    output logic [BITS-1:0] s
);
    always_comb begin
        if (a > b) begin
            d = a - b;
            s = a - b;
        end else begin
            d = b - a;
            s = '0;
        end
    end
endmodule

module frame_diff_filter_core #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int OUT_FIFO_DEPTH   = 4,
    parameter int COUNT_BITS       = 32
) (
    input logic             clk,
    input logic             rst_n,
    frame_diff_filter_if.slave bus
);
    localparam int W  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int AW = $clog2(OUT_FIFO_DEPTH);

    typedef logic [SYMBOLS_PER_BEAT-1:0][BITS_PER_SYMBOL-1:0] chan_t;

    // ------------------------------------------------------------------
    // Credit / accept
    // ------------------------------------------------------------------
    logic          run;          // low during reset, high from first clock after
    logic [AW:0]   fifo_count;
    logic          s1_valid;
    logic [AW+1:0] occ;
    logic          read;
    logic          accept;

    // Credit counts entries already in the FIFO plus the one in flight in S1,
    // so a beat granted now always has a slot when it reaches the FIFO.
    assign occ    = (AW+2)'(fifo_count) + (AW+2)'(s1_valid);
    assign read   = run & (occ < (AW+2)'(OUT_FIFO_DEPTH));
    assign accept = read & ~bus.stall_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Frame shadowing of mode / threshold
    // ------------------------------------------------------------------
    logic                       frame_start;
    logic [1:0]                 active_mode;
    logic [BITS_PER_SYMBOL-1:0] active_thr;
    logic [1:0]                 eff_mode;
    logic [BITS_PER_SYMBOL-1:0] eff_thr;

    // The first beat of a frame must already use the values being captured.
    assign eff_mode = frame_start ? bus.mode_in      : active_mode;
    assign eff_thr  = frame_start ? bus.threshold_in : active_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b1;
            active_mode <= 2'b00;
            active_thr  <= '0;
        end else if (accept) begin
            frame_start <= bus.end_of_video;
            if (frame_start) begin
                active_mode <= bus.mode_in;
                active_thr  <= bus.threshold_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel difference lanes
    // ------------------------------------------------------------------
    chan_t a_ch, b_ch, d_c, s_c;
    assign a_ch = bus.data_A_in;
    assign b_ch = bus.data_B_in;

    for (genvar i = 0; i < SYMBOLS_PER_BEAT; i++) begin : g_lane
        frame_diff_lane #(.BITS(BITS_PER_SYMBOL)) u_lane (
            .a (a_ch[i]),
            .b (b_ch[i]),
            .d (d_c[i]),
            .s (s_c[i])
        );
    end

    logic [BITS_PER_SYMBOL-1:0] max_d;
    always_comb begin
        max_d = '0;
        for (int i = 0; i < SYMBOLS_PER_BEAT; i++)
            if (d_c[i] > max_d) max_d = d_c[i];
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    chan_t                      s1_d, s1_s;
    logic                       s1_eop;
    logic                       s1_above;
    logic [1:0]                 s1_mode;
    logic [BITS_PER_SYMBOL-1:0] s1_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_s     <= '0;
            s1_eop   <= 1'b0;
            s1_above <= 1'b0;
            s1_mode  <= 2'b00;
            s1_thr   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_d     <= d_c;
                s1_s     <= s_c;
                s1_eop   <= bus.end_of_video;
                s1_above <= max_d > eff_thr;
                s1_mode  <= eff_mode;
                s1_thr   <= eff_thr;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 mode select
    // ------------------------------------------------------------------
    chan_t res;
    always_comb begin
        res = '0;
        for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
            case (s1_mode)
                2'b00:   res[i] = s1_d[i];
                2'b01:   res[i] = s1_s[i];
                2'b10:   res[i] = (s1_d[i] > s1_thr) ? '1 : '0;
                default: res[i] = s1_above ? '1 : '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO ({eop, data} per entry)
    // ------------------------------------------------------------------
    logic [W:0]    mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, write;
    logic [W:0]    head;

    assign push  = s1_valid;
    assign write = (fifo_count != '0);
    assign pop   = write & ~bus.stall_out;
    assign head  = mem[rd_ptr];

    // Storage needs no reset: nothing is visible unless fifo_count says so.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s1_eop, W'(res)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Motion counter (runs off S1, independent of downstream stalls)
    // ------------------------------------------------------------------
    logic [COUNT_BITS-1:0] cnt, cnt_inc, mc_out;
    logic                  mc_valid;

    assign cnt_inc = (&cnt) ? cnt : cnt + COUNT_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            mc_out   <= '0;
            mc_valid <= 1'b0;
        end else begin
            mc_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_eop) begin
                    mc_out   <= s1_above ? cnt_inc : cnt;
                    cnt      <= '0;
                    mc_valid <= 1'b1;
                end else if (s1_above) begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.read               = read;
    assign bus.write              = write;
    assign bus.data_out           = write ? head[W-1:0] : '0;
    assign bus.end_of_video_out   = write & head[W];
    assign bus.motion_count_out   = mc_out;
    assign bus.motion_count_valid = mc_valid;

    assign bus.width_out          = bus.width_in;
    assign bus.height_out         = bus.height_in;
    assign bus.interlaced_out     = bus.interlaced_in;
    assign bus.vip_ctrl_valid_out = bus.vip_ctrl_valid_in;
endmodule

// File: tb/tb_frame_diff_filter_core.sv
// tb_frame_diff_filter_core
//   Directed stimulus with literal expectations, plus a transaction-level
//   reference model (queue of expected results, per-frame count list) that is
//   compared against the DUT outputs on every clock.
module tb_frame_diff_filter_core;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_diff_filter_if #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .COUNT_BITS(32)) bus ();

    frame_diff_filter_core #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .OUT_FIFO_DEPTH(4), .COUNT_BITS(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         eop;
        int           cyc;
    } ent_t;

    ent_t        q[$];
    int          mc_due[$];
    int          mc_val[$];
    int          cyc = 0;
    bit          m_run = 0;
    bit          m_fs = 1;
    logic [1:0]  m_mode = 0;
    logic [7:0]  m_thr = 0;
    int          m_cnt = 0;
    int          m_mc_hold = 0;

    function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] mode, input logic [7:0] thr,
                                               output bit above);
        logic [W-1:0] r;
        int ai, bi, d, mx;
        r = '0;
        mx = 0;
        for (int ch = 0; ch < 3; ch++) begin
            ai = int'(a[ch*8 +: 8]);
            bi = int'(b[ch*8 +: 8]);
            d  = (ai > bi) ? ai - bi : bi - ai;
            if (d > mx) mx = d;
            case (mode)
                2'd0: r[ch*8 +: 8] = 8'(d);
                2'd1: r[ch*8 +: 8] = (ai > bi) ? 8'(ai - bi) : 8'h00;
                2'd2: r[ch*8 +: 8] = (d > int'(thr)) ? 8'hFF : 8'h00;
                default: ;
            endcase
        end
        above = mx > int'(thr);
        if (mode == 2'd3) r = above ? {W{1'b1}} : '0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mc_due.delete();
            mc_val.delete();
            m_run = 0;
            m_fs = 1;
            m_mode = 0;
            m_thr = 0;
            m_cnt = 0;
            m_mc_hold = 0;
        end else begin
            ent_t e;
            bit ab;
            if (bus.write && !bus.stall_out && q.size() > 0) void'(q.pop_front());
            if (bus.read && !bus.stall_in) begin
                if (m_fs) begin
                    m_mode = bus.mode_in;
                    m_thr  = bus.threshold_in;
                end
                m_fs   = bus.end_of_video;
                e.data = model_res(bus.data_A_in, bus.data_B_in, m_mode, m_thr, ab);
                e.eop  = bus.end_of_video;
                e.cyc  = cyc;
                q.push_back(e);
                if (ab) m_cnt++;
                if (bus.end_of_video) begin
                    mc_due.push_back(cyc + 2);
                    mc_val.push_back(m_cnt);
                    m_cnt = 0;
                end
            end
            m_run = 1;
            cyc++;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_w;
            bit exp_mv;
            exp_w = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            chk("read", bus.read, m_run && (q.size() < 4));
            chk("write", bus.write, exp_w);
            if (exp_w) begin
                chk("data_out", bus.data_out, q[0].data);
                chk("eov_out", bus.end_of_video_out, q[0].eop);
            end
            exp_mv = (mc_due.size() > 0) && (mc_due[0] == cyc);
            chk("mc_valid", bus.motion_count_valid, exp_mv);
            if (exp_mv) begin
                m_mc_hold = mc_val[0];
                void'(mc_due.pop_front());
                void'(mc_val.pop_front());
            end
            chk("mc_out", bus.motion_count_out, 64'(m_mc_hold));
        end
    end

    // ---------------- directed stimulus ----------------
    logic       last_mcv;
    logic [31:0] last_mc;

    // One isolated beat, entered at #1 after a posedge; checks the result
    // appears exactly two cycles after accept. Returns #1 after a posedge.
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                        input logic [7:0] thr, input logic eop, input logic [W-1:0] exp);
        int n = 0;
        bus.data_A_in = a;
        bus.data_B_in = b;
        bus.mode_in = mode;
        bus.threshold_in = thr;
        bus.end_of_video = eop;
        bus.stall_in = 1'b0;
        @(negedge clk);
        while (!bus.read && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("read_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.stall_in = 1'b1;
        bus.end_of_video = 1'b0;
        @(negedge clk);
        chk("lat_early", bus.write, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_write", bus.write, 1'b1);
        chk("lit_data", bus.data_out, exp);
        last_mcv = bus.motion_count_valid;
        last_mc  = bus.motion_count_out;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, guard;
        bus.stall_in = 1'b1;
        bus.stall_out = 1'b0;
        bus.data_A_in = '0;
        bus.data_B_in = '0;
        bus.end_of_video = 1'b0;
        bus.mode_in = 2'b00;
        bus.threshold_in = 8'h00;
        bus.width_in = 16'h0780;
        bus.height_in = 16'h0438;
        bus.interlaced_in = 4'hA;
        bus.vip_ctrl_valid_in = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", bus.read, 1'b0);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_data", bus.data_out, 24'h0);
        chk("rst_eov", bus.end_of_video_out, 1'b0);
        chk("rst_mc", bus.motion_count_out, 32'h0);
        chk("rst_mcv", bus.motion_count_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_read", bus.read, 1'b1);

        // control passthrough (zero latency)
        #1;
        chk("pt_width", bus.width_out, 16'h0780);
        chk("pt_height", bus.height_out, 16'h0438);
        chk("pt_intl", bus.interlaced_out, 4'hA);
        chk("pt_vld", bus.vip_ctrl_valid_out, 1'b1);
        bus.width_in = 16'h0500;
        bus.vip_ctrl_valid_in = 1'b0;
        #1;
        chk("pt_width2", bus.width_out, 16'h0500);
        chk("pt_vld2", bus.vip_ctrl_valid_out, 1'b0);

        @(posedge clk);
        #1;
        // each mode on single-beat frames
        beat(24'h1080FF, 24'h208000, 2'b00, 8'h00, 1'b1, 24'h1000FF);
        beat(24'h1080FF, 24'h208000, 2'b01, 8'h00, 1'b1, 24'h0000FF);
        beat(24'h1080FF, 24'h208000, 2'b10, 8'h0F, 1'b1, 24'hFF00FF);
        beat(24'h1080FF, 24'h208000, 2'b11, 8'hFE, 1'b1, 24'hFFFFFF);
        chk("lit_mc_fe", last_mc, 32'd1);
        beat(24'h1080FF, 24'h208000, 2'b11, 8'hFF, 1'b1, 24'h000000);
        chk("lit_mc_ff", last_mc, 32'd0);

        // 10-beat frame, beats 2/5/8 just above 0x40, others exactly at 0x40
        for (int i = 0; i < 10; i++) begin
            bit ab;
            ab = (i == 2 || i == 5 || i == 8);
            beat({16'h0000, ab ? 8'h41 : 8'h40}, 24'h000000, 2'b11, 8'h40, i == 9,
                 ab ? 24'hFFFFFF : 24'h000000);
        end
        chk("lit_mcv_frame", last_mcv, 1'b1);
        chk("lit_mc_frame", last_mc, 32'd3);
        beat(24'h000041, 24'h0, 2'b11, 8'h40, 1'b0, 24'hFFFFFF);
        beat(24'h0000FF, 24'h0, 2'b11, 8'h40, 1'b1, 24'hFFFFFF);
        chk("lit_mc_next", last_mc, 32'd2);

        // mode change mid-frame takes effect on next frame
        beat(24'h101010, 24'h202020, 2'b00, 8'h00, 1'b0, 24'h101010);
        beat(24'h101010, 24'h202020, 2'b01, 8'h00, 1'b0, 24'h101010);
        beat(24'h101010, 24'h202020, 2'b01, 8'h00, 1'b1, 24'h101010);
        beat(24'h101010, 24'h202020, 2'b01, 8'h00, 1'b1, 24'h000000);

        // back-to-back stream with random downstream stalls
        k = 0;
        guard = 0;
        bus.mode_in = 2'b00;
        bus.threshold_in = 8'h30;
        while (k < 16 && guard < 400) begin
            bus.data_A_in = 24'(k * 37 + 5) ^ 24'h5A0000;
            bus.data_B_in = 24'(k * 91);
            bus.end_of_video = (k == 15);
            bus.stall_in = 1'b0;
            bus.stall_out = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.read) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.stall_in = 1'b1;
        bus.end_of_video = 1'b0;
        bus.stall_out = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stream_accepted", 32'(k), 32'd16);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // reset with three entries held in the FIFO
        @(posedge clk);
        #1;
        bus.stall_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_A_in = 24'(i + 1) << 4;
            bus.data_B_in = 24'h0;
            bus.mode_in = 2'b01;
            bus.end_of_video = 1'b0;
            bus.stall_in = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.stall_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_write", bus.write, 1'b1);
        chk("pre_rst_data", bus.data_out, 24'h000010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", bus.write, 1'b0);
        chk("mid_rst_data", bus.data_out, 24'h0);
        chk("mid_rst_read", bus.read, 1'b0);
        chk("mid_rst_count", dut.fifo_count, 0);
        chk("mid_rst_mode", dut.active_mode, 2'b00);
        bus.stall_out = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_read", bus.read, 1'b1);
        chk("post_rst_write", bus.write, 1'b0);
        @(posedge clk);
        #1;
        beat(24'h3020FF, 24'h402001, 2'b01, 8'h00, 1'b1, 24'h0000FE);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frame_diff_filter_core.md
# frame_diff_filter_core

Parametrised successor of the per-pixel absolute-difference core. It takes two aligned pixel streams, A and B. For each beat it computes one of four selectable per-channel difference results: absolute difference, saturating A−B, per-channel threshold mask, or whole-pixel motion mask. Results go through a two-stage pipeline and a credit-controlled output FIFO. The block sits between the VIP control packet decoder and encoder flow-control wrappers, passes control-packet fields through unchanged, and reports a per-frame count of pixels above threshold.

## Interface
Parameters:
- BITS_PER_SYMBOL, 8, width of one colour symbol.
- SYMBOLS_PER_BEAT, 3, channels per beat; any value ≥1, all processed.
- OUT_FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- COUNT_BITS, 32, width of the motion counter.

Ports (W = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_in  in  1  input side has no valid beat.
- read  out  1  core requests a beat.
- data_A_in, data_B_in  in  W  pixel beats; symbol 0 in LSBs.
- end_of_video  in  1  last beat of frame, qualified with the beat.
- mode_in  in  2  00 absdiff, 01 sat A−B, 10 channel mask, 11 pixel mask.
- threshold_in  in  BITS_PER_SYMBOL  mask and count threshold.
- stall_out  in  1  downstream cannot accept.
- write  out  1  data_out/end_of_video_out valid.
- data_out  out  W  result beat.
- end_of_video_out  out  1  end-of-frame flag travelling with the result.
- motion_count_out  out  COUNT_BITS  pixels above threshold in the last completed frame.
- motion_count_valid  out  1  one-cycle pulse when motion_count_out updates.
- width_in/out 16, height_in/out 16, interlaced_in/out 4, vip_ctrl_valid_in/out 1: combinational passthrough.

## Operation
- Accept: a beat transfers in any cycle where read & ~stall_in.
- Credit: read = (fifo_count + s1_valid) < OUT_FIFO_DEPTH. This is computed from registered state only. A pop in the same cycle does not grant a credit.
- Frame shadowing: a frame_start flag is set at reset and by an accepted end_of_video beat. On the first accepted beat of a frame, mode_in and threshold_in are captured into active_mode and active_thr. They are held for the whole frame, so changes mid-frame take effect on the next frame. The shadow registers reset to 00 and 0.
- Stage S1, registered on accept: per channel i, d_i = |A_i−B_i| (unsigned, BITS_PER_SYMBOL wide), s_i = A_i>B_i ? A_i−B_i : 0, and the eop flag. Also registered: above = (max_i d_i > active_thr), strictly greater.
- Stage S2, combinational from S1 and written to the FIFO when s1_valid:
  - 00: d_i.
  - 01: s_i.
  - 10: d_i > active_thr ? all-ones : 0, per channel.
  - 11: every channel = above ? all-ones : 0.
  - eop copied through with the result.
- FIFO: push when s1_valid; pop when write & ~stall_out. write = ~empty. data_out and end_of_video_out show the head entry and hold stable while stalled. Push and pop in the same cycle leave the count unchanged. Overflow cannot occur because of the credit rule.
- Counter:
  - When s1_valid & above, cnt increments, saturating at all-ones.
  - When s1_valid & eop: motion_count_out <= sat(cnt + above), cnt <= 0, and motion_count_valid pulses in the next cycle.
  - This path is independent of stall_out.
- Reset mid-operation: pipeline, FIFO, counter and shadow registers clear immediately. Partial frame data is discarded.

## Timing
- Reset values: read=0 while rst_n=0, then 1 from the first cycle after release. write=0, data_out=0, end_of_video_out=0, motion_count_out=0, motion_count_valid=0.
- Latency: a beat accepted in cycle t appears with write=1 in cycle t+2 if the FIFO was empty. Otherwise it follows all earlier entries in order.
- Throughput: one beat per cycle sustained while stall_out=0.
- stall_out rising: read drops once fifo_count + s1_valid reaches OUT_FIFO_DEPTH. No beat is lost or duplicated.
- motion_count_valid: asserted in cycle t+2 for an eop beat accepted in cycle t, for exactly one cycle.
- Control passthrough: zero latency.

## Test plan
- Mode 00, A=0x10_80_FF, B=0x20_80_00, stall_out=0 -> data_out=0x10_00_FF exactly 2 cycles after accept.
- Mode 01, same inputs -> 0x00_00_FF; mode 10 with thr=0x0F -> 0xFF_00_FF; mode 11 with thr=0xFE -> 0xFF_FF_FF; mode 11 with thr=0xFF -> 0x000000.
- Back-to-back stream of 16 beats with random stall_out (50%) -> output sequence identical to the input order. read is 0 whenever fifo_count + s1_valid = 4, and there is never an overflow or drop.
- Frame of 10 beats with 3 above thr=0x40 (mode 11), eop on beat 10 -> motion_count_out=3 with a one-cycle motion_count_valid 2 cycles after the eop accept. The next frame's count starts from 0.
- mode_in changed from 00 to 01 mid-frame -> remaining beats of that frame still absdiff; the first beat of the next frame uses sat A−B.
- rst_n asserted with 3 entries in the FIFO -> write=0 and data_out=0 immediately, count=0, shadow mode=00. After release, read=1 from the first cycle.
